fft_r2_seq_ctrl: RTL

- Sequencer for an in-place radix-2 decimation-in-time FFT built around a single shared 2-point butterfly unit and an N-word sample RAM.
- Controls the whole job in order:
  - Load samples into the RAM in bit-reversed order.
  - Issue every butterfly pair address and twiddle index, stage by stage.
  - Wait for butterfly write-backs to drain before starting the next stage.
  - Read results out in natural order.
- Holds no sample data; it only produces addresses, indices, strobes and status.

---
 rtl/fft_r2_seq_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fft_r2_seq_ctrl.sv
// Sequencer for an in-place radix-2 DIT FFT around one shared butterfly:
// bit-reversed load, stage-by-stage issue with write-back drain, natural-order unload.
module fft_r2_seq_ctrl #(
    parameter int unsigned LOG2N = 3
) (
    input  logic             sys_clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    input  logic             load_valid_i,
    output logic [LOG2N-1:0] load_addr_o,
    output logic             bf_valid_o,
    input  logic             bf_ready_i,
    output logic [LOG2N-1:0] bf_addr_a_o,
    output logic [LOG2N-1:0] bf_addr_b_o,
    output logic [LOG2N-2:0] bf_tw_idx_o,
    output logic [3:0]       bf_stage_o,
    input  logic             wb_valid_i,
    output logic             unload_valid_o,
    input  logic             unload_ready_i,
    output logic [LOG2N-1:0] unload_addr_o
);
    localparam int unsigned      N          = 2 ** LOG2N;
    localparam int unsigned      TW_W       = LOG2N - 1;
    localparam logic [LOG2N-1:0] K_LAST     = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] WB_FULL    = LOG2N'(N / 2);
    localparam logic [3:0]       STAGE_LAST = 4'(LOG2N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LOG2N-1:0]  k_q, k_d;
    logic [TW_W-1:0]   j_q, j_d;
    logic [3:0]        s_q, s_d;
    logic [LOG2N-1:0]  wb_q, wb_d;
    logic [LOG2N-1:0]  m_q, m_d;
    logic              err_q, err_d;

    logic [LOG2N-1:0]  k_rev;
    logic [LOG2N-1:0]  j_ext, pos, grp, addr_a, addr_b;
    logic [3:0]        tw_sh;
    logic [TW_W-1:0]   tw_idx;

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            j_q     <= '0;
            s_q     <= '0;
            wb_q    <= '0;
            m_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            s_q     <= s_d;
            wb_q    <= wb_d;
            m_q     <= m_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        k_rev = '0;
        for (int unsigned i = 0; i < LOG2N; i++) begin
            k_rev[i] = k_q[LOG2N-1-i];
        end
    end

    // Pair j of stage s: h=2^s, addr_a = (j>>s)*2h + (j & (h-1)), addr_b = addr_a + h.
    always_comb begin
        j_ext  = LOG2N'(j_q);
        pos    = j_ext & ((LOG2N'(1) << s_q) - LOG2N'(1));
        grp    = j_ext >> s_q;
        addr_a = (grp << (s_q + 4'd1)) | pos;
        addr_b = addr_a | (LOG2N'(1) << s_q);
        tw_sh  = STAGE_LAST - s_q;
        tw_idx = TW_W'(pos << tw_sh);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        s_d     = s_q;
        wb_d    = wb_q;
        m_d     = m_q;
        err_d   = err_q;

        if ((state_q == S_ISSUE || state_q == S_DRAIN) && wb_valid_i) begin
            if (wb_q == WB_FULL) begin
                err_d = 1'b1;
            end else begin
                wb_d = wb_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    k_d     = '0;
                    s_d     = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (load_valid_i) begin
                    k_d = k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = S_ISSUE;
                        j_d     = '0;
                        wb_d    = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (bf_ready_i) begin
                    j_d = j_q + 1'b1;
                    if (j_q == '1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // wb_d already includes a write-back landing this cycle
                if (wb_d == WB_FULL) begin
                    if (s_q != STAGE_LAST) begin
                        state_d = S_ISSUE;
                        s_d     = s_q + 4'd1;
                        j_d     = '0;
                        wb_d    = '0;
                    end else begin
                        state_d = S_UNLOAD;
                        m_d     = '0;
                    end
                end
            end
            S_UNLOAD: begin
                if (unload_ready_i) begin
                    m_d = m_q + 1'b1;
                    if (m_q == K_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign err_o          = err_q;
    assign load_addr_o    = (state_q == S_LOAD) ? k_rev : '0;
    assign bf_valid_o     = (state_q == S_ISSUE);
    assign bf_addr_a_o    = (state_q == S_ISSUE) ? addr_a : '0;
    assign bf_addr_b_o    = (state_q == S_ISSUE) ? addr_b : '0;
    assign bf_tw_idx_o    = (state_q == S_ISSUE) ? tw_idx : '0;
    assign bf_stage_o     = s_q;
    assign unload_valid_o = (state_q == S_UNLOAD);
    assign unload_addr_o  = (state_q == S_UNLOAD) ? m_q : '0;

endmodule
